// File: rtl/secret_accum.sv
// Leaf block: registered accumulator with a hidden per-cycle constant, a bypass mux,
// and pass-through channels. Define SECRET_PASS_REG_EN to register the sN channels.
`timescale 1ns/1ps

module secret_accum #(
    parameter logic [31:0] SECRET_VALUE = 32'd7,
    parameter int unsigned ACCUM_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ACCUM_W-1:0]   accum_in,
    output logic [ACCUM_W-1:0]   accum_out,
    input  logic                 accum_bypass,
    output logic [ACCUM_W-1:0]   accum_bypass_out,
    input  logic                 s1_in,
    output logic                 s1_out,
    input  logic [1:0]           s2_in,
    output logic [1:0]           s2_out,
    input  logic [7:0]           s8_in,
    output logic [7:0]           s8_out,
    input  logic [32:0]          s33_in,
    output logic [32:0]          s33_out,
    input  logic [63:0]          s64_in,
    output logic [63:0]          s64_out,
    input  logic [64:0]          s65_in,
    output logic [64:0]          s65_out,
    input  logic [128:0]         s129_in,
    output logic [128:0]         s129_out,
    input  logic [3:0][31:0]     s4x32_in,
    output logic [3:0][31:0]     s4x32_out
);

    // The constant is resized to the datapath so the sum wraps modulo 2^ACCUM_W.
    localparam logic [ACCUM_W-1:0] SECRET_W = ACCUM_W'(SECRET_VALUE);

    logic [ACCUM_W-1:0] accum_q;

    // No handshake: a new addend is consumed on every rising edge; reset wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            accum_q <= '0;
        end else begin
            accum_q <= accum_q + accum_in + SECRET_W;
        end
    end

    assign accum_out        = accum_q;
    assign accum_bypass_out = accum_bypass ? accum_in : accum_q;

`ifdef SECRET_PASS_REG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_out    <= '0;
            s2_out    <= '0;
            s8_out    <= '0;
            s33_out   <= '0;
            s64_out   <= '0;
            s65_out   <= '0;
            s129_out  <= '0;
            s4x32_out <= '0;
        end else begin
            s1_out    <= s1_in;
            s2_out    <= s2_in;
            s8_out    <= s8_in;
            s33_out   <= s33_in;
            s64_out   <= s64_in;
            s65_out   <= s65_in;
            s129_out  <= s129_in;
            s4x32_out <= s4x32_in;
        end
    end
`else
    assign s1_out    = s1_in;
    assign s2_out    = s2_in;
    assign s8_out    = s8_in;
    assign s33_out   = s33_in;
    assign s64_out   = s64_in;
    assign s65_out   = s65_in;
    assign s129_out  = s129_in;
    assign s4x32_out = s4x32_in;
`endif

endmodule

// File: tb/tb_secret_accum.sv
// Self-checking bench for secret_accum: accumulator scoreboard, bypass mux and
// pass-through channels (combinational, or registered with SECRET_PASS_REG_EN).
`timescale 1ns/1ps

module tb_secret_accum;

    localparam int W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [W-1:0]     accum_in = '0;
    logic [W-1:0]     accum_out;
    logic             accum_bypass = 1'b0;
    logic [W-1:0]     accum_bypass_out;
    logic             s1_in = '0;
    logic             s1_out;
    logic [1:0]       s2_in = '0;
    logic [1:0]       s2_out;
    logic [7:0]       s8_in = '0;
    logic [7:0]       s8_out;
    logic [32:0]      s33_in = '0;
    logic [32:0]      s33_out;
    logic [63:0]      s64_in = '0;
    logic [63:0]      s64_out;
    logic [64:0]      s65_in = '0;
    logic [64:0]      s65_out;
    logic [128:0]     s129_in = '0;
    logic [128:0]     s129_out;
    logic [3:0][31:0] s4x32_in = '0;
    logic [3:0][31:0] s4x32_out;

    logic [W-1:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    secret_accum #(.SECRET_VALUE(32'd7), .ACCUM_W(W)) dut (
        .clk(clk), .rst(rst),
        .accum_in(accum_in), .accum_out(accum_out),
        .accum_bypass(accum_bypass), .accum_bypass_out(accum_bypass_out),
        .s1_in(s1_in), .s1_out(s1_out),
        .s2_in(s2_in), .s2_out(s2_out),
        .s8_in(s8_in), .s8_out(s8_out),
        .s33_in(s33_in), .s33_out(s33_out),
        .s64_in(s64_in), .s64_out(s64_out),
        .s65_in(s65_in), .s65_out(s65_out),
        .s129_in(s129_in), .s129_out(s129_out),
        .s4x32_in(s4x32_in), .s4x32_out(s4x32_out)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver: apply inputs for the next edge, push the expected accum_out,
    // then advance to just after that edge.
    task automatic drive_cycle(input logic r, input logic [W-1:0] din, input logic [W-1:0] exp);
        rst      = r;
        accum_in = din;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pattern(input logic [511:0] p);
        s1_in    = p[0];
        s2_in    = p[1:0];
        s8_in    = p[7:0];
        s33_in   = p[32:0];
        s64_in   = p[63:0];
        s65_in   = p[64:0];
        s129_in  = p[128:0];
        s4x32_in = p[127:0];
    endtask

    task automatic test_reset();
        logic [W-1:0] e;
        logic [W-1:0] tbl[4] = '{32'd0, 32'd7, 32'd14, 32'd21};
        drive_cycle(1'b1, 32'd0, tbl[0]);
        for (int i = 1; i < 4; i++) begin
            vectors++;
            e = exp_q.pop_front();
            if (accum_out !== e) begin
                $display("FAIL reset_accum[%0d]: got %h expected %h", i - 1, accum_out, e);
                miscompares++;
            end
            drive_cycle(1'b0, 32'd0, tbl[i]);
        end
        vectors++;
        e = exp_q.pop_front();
        if (accum_out !== e) begin
            $display("FAIL reset_accum[3]: got %h expected %h", accum_out, e);
            miscompares++;
        end
        vectors++;
        if (accum_bypass_out !== 32'd21) begin
            $display("FAIL reset_bypass_off: got %h expected %h", accum_bypass_out, 32'd21);
            miscompares++;
        end
    endtask

    task automatic test_growing();
        logic [W-1:0] e;
        logic [W-1:0] din[3] = '{32'd100, 32'd105, 32'd110};
        logic [W-1:0] res[3] = '{32'd107, 32'd219, 32'd336};
        drive_cycle(1'b1, 32'd0, 32'd0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, din[i], res[i]);
            vectors++;
            e = exp_q.pop_front();
            if (accum_out !== e) begin
                $display("FAIL growing[%0d]: got %h expected %h", i, accum_out, e);
                miscompares++;
            end
        end
    endtask

    task automatic test_bypass();
        logic [W-1:0] e;
        accum_bypass = 1'b1;
        accum_in     = 32'h1234;
        #1;
        vectors++;
        if (accum_bypass_out !== 32'h1234) begin
            $display("FAIL bypass_same_cycle: got %h expected %h", accum_bypass_out, 32'h1234);
            miscompares++;
        end
        drive_cycle(1'b0, 32'h1234, 32'd336 + 32'h1234 + 32'd7);
        vectors++;
        e = exp_q.pop_front();
        if (accum_out !== e) begin
            $display("FAIL bypass_accum_continues: got %h expected %h", accum_out, e);
            miscompares++;
        end
        vectors++;
        if (accum_bypass_out !== 32'h1234) begin
            $display("FAIL bypass_held: got %h expected %h", accum_bypass_out, 32'h1234);
            miscompares++;
        end
        accum_bypass = 1'b0;
        #1;
        vectors++;
        if (accum_bypass_out !== 32'd5003) begin
            $display("FAIL bypass_cleared: got %h expected %h", accum_bypass_out, 32'd5003);
            miscompares++;
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] e;
        drive_cycle(1'b1, 32'd0, 32'd0);
        void'(exp_q.pop_front());
        drive_cycle(1'b0, 32'hFFFF_FFE9, 32'hFFFF_FFF0);
        vectors++;
        e = exp_q.pop_front();
        if (accum_out !== e) begin
            $display("FAIL wrap_preload: got %h expected %h", accum_out, e);
            miscompares++;
        end
        drive_cycle(1'b0, 32'h10, 32'h0000_0007);
        vectors++;
        e = exp_q.pop_front();
        if (accum_out !== e) begin
            $display("FAIL wrap_result: got %h expected %h", accum_out, e);
            miscompares++;
        end
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] e;
        logic         r_t[3] = '{1'b0, 1'b1, 1'b0};
        logic [W-1:0] d_t[3] = '{32'd5, 32'h55, 32'd3};
        logic [W-1:0] x_t[3] = '{32'd19, 32'd0, 32'd10};
        for (int i = 0; i < 3; i++) begin
            drive_cycle(r_t[i], d_t[i], x_t[i]);
            vectors++;
            e = exp_q.pop_front();
            if (accum_out !== e) begin
                $display("FAIL mid_reset[%0d]: got %h expected %h", i, accum_out, e);
                miscompares++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] model;
        logic [W-1:0] din;
        logic [W-1:0] e;
        logic         r;
        model = '0;
        for (int i = 0; i < 40; i++) begin
            r   = (i == 0) || ($urandom_range(0, 9) == 0);
            din = $urandom;
            accum_bypass = 1'($urandom_range(0, 1));
            model = r ? '0 : model + din + 32'd7;
            drive_cycle(r, din, model);
            vectors++;
            e = exp_q.pop_front();
            if (accum_out !== e) begin
                $display("FAIL b2b_accum[%0d]: got %h expected %h", i, accum_out, e);
                miscompares++;
            end
            vectors++;
            if (accum_bypass_out !== (accum_bypass ? din : model)) begin
                $display("FAIL b2b_bypass[%0d]: got %h expected %h", i, accum_bypass_out,
                         accum_bypass ? din : model);
                miscompares++;
            end
        end
        accum_bypass = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_pass_through();
        logic [511:0] pat;
        logic [511:0] ref_p;
        pat = {8{64'h5aef0c8dd70a4497}};
`ifdef SECRET_PASS_REG_EN
        drive_pattern(pat);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if ({s129_out, s65_out, s64_out, s33_out, s8_out, s2_out, s1_out, s4x32_out} !== '0) begin
            $display("FAIL pass_reset: got nonzero outputs expected 0");
            miscompares++;
        end
`endif
        for (int i = 0; i < 8; i++) begin
            pat = {pat[504:0], pat[511:505]} ^ {16{32'($urandom)}};
            drive_pattern(pat);
`ifdef SECRET_PASS_REG_EN
            ref_p = pat;
            @(posedge clk);
            #1;
            pat = ~pat;
            drive_pattern(pat);
`else
            #1;
            ref_p = pat;
`endif
            vectors++;
            if (s1_out !== ref_p[0] || s2_out !== ref_p[1:0] || s8_out !== ref_p[7:0]) begin
                $display("FAIL pass_narrow[%0d]: got %b %b %h expected %b %b %h", i,
                         s1_out, s2_out, s8_out, ref_p[0], ref_p[1:0], ref_p[7:0]);
                miscompares++;
            end
            vectors++;
            if (s33_out !== ref_p[32:0] || s64_out !== ref_p[63:0] || s65_out !== ref_p[64:0]) begin
                $display("FAIL pass_mid[%0d]: got %h %h %h expected %h %h %h", i,
                         s33_out, s64_out, s65_out, ref_p[32:0], ref_p[63:0], ref_p[64:0]);
                miscompares++;
            end
            vectors++;
            if (s129_out !== ref_p[128:0] || s129_out[128] !== ref_p[128]) begin
                $display("FAIL pass_s129[%0d]: got %h expected %h", i, s129_out, ref_p[128:0]);
                miscompares++;
            end
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (s4x32_out[k] !== ref_p[32*k +: 32]) begin
                    $display("FAIL pass_s4x32[%0d][%0d]: got %h expected %h", i, k,
                             s4x32_out[k], ref_p[32*k +: 32]);
                    miscompares++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_growing();
        test_bypass();
        test_wrap();
        test_mid_reset();
        test_back_to_back();
        test_pass_through();
        vectors++;
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
